partition_stats: RTL
====================

Name: partition_stats

Overview:
- Sequential producer of the control inputs consumed by the quickselect next-state logic.
- Streams one candidate buffer of 8-bit samples against a latched pivot.
- Counts lower/equal/larger samples and tracks min/max of the lower and larger partitions.
- Re-emits each sample tagged with its partition so the next iteration's buffer can be written; holds results until the consumer acknowledges them.

Parameters:
- BUFF_SIZE, 32, maximum samples per pass.
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of size/position fields.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches pivot/median_pos/buff_size; honoured only in IDLE.
- in_pivot  in  8  pivot for this pass.
- in_median_pos  in  BUFF_SIZE_BIT  median position for this pass.
- in_buff_size  in  BUFF_SIZE_BIT  number of samples in this pass.
- in_sample  in  8  sample data.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts a sample.
- out_sample  out  8  registered copy of the accepted sample.
- out_part  out  2  partition tag: 00 lower, 01 equal, 10 larger.
- out_valid  out  1  out_sample/out_part valid; no backpressure.
- lower_size, equal_size, larger_size  out  BUFF_SIZE_BIT each  partition counts.
- max_lower, min_lower, max_larger, min_larger  out  8 each  partition extrema.
- pivot_q  out  8  latched pivot.
- median_pos_q  out  BUFF_SIZE_BIT  latched median position.
- result_valid  out  1  counts and extrema final.
- result_ready  in  1  consumer acknowledge.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, rst_n=0), state goes to IDLE and:
  - all counts, pivot_q, median_pos_q, out_sample, out_part and out_valid are 0;
  - result_valid is 0;
  - min_lower and min_larger are 8'hFF; max_lower and max_larger are 8'h00.
- Reset asserted mid-RUN or mid-DONE aborts the pass and discards partial results.
- IDLE:
  - in_ready=0.
  - On start, latch pivot/median_pos and set target = min(in_buff_size, BUFF_SIZE).
  - Clear counts and accepted counter; reload extrema to FF/00.
  - Go to RUN, or directly to DONE if target==0; counts are then 0 and extrema stay FF/00.
- RUN:
  - in_ready=1; a sample is accepted when in_valid && in_ready.
  - Accepted sample s goes to lower if s<pivot_q, equal if s==pivot_q, else larger.
  - Only the matching count increments; only the matching partition's min/max update (unsigned compare).
  - Next cycle: out_sample=s, out_part=tag, out_valid=1. Otherwise out_valid=0.
  - When the accepted counter reaches target, go to DONE.
  - in_ready drops on the cycle after the last acceptance.
  - start is ignored in RUN.
- DONE:
  - result_valid=1; all result outputs are held stable.
  - Latency: result_valid rises the cycle after the last sample is accepted, coincident with the last out_valid.
  - On result_valid && result_ready, go to IDLE; result_valid=0 next cycle; result outputs keep their values until the next start.
  - start is ignored in DONE, including when it arrives in the same cycle as result_ready.
- Invariants:
  - lower_size+equal_size+larger_size == target at DONE.
  - Counts never exceed BUFF_SIZE; no wrap.
  - An empty partition reports min=FF, max=00; consumers must not select an empty partition.

Optional Feature:
- Macro: PARTITION_MEDIAN_FOUND_EN.
- When defined:
  - Adds output median_found (1 bit), registered, valid with result_valid.
  - median_found = (lower_size <= median_pos_q) && (lower_size+equal_size > median_pos_q); the sum is computed at BUFF_SIZE_BIT+1 bits.
  - Reset value 0; cleared on start.
- When undefined: port and logic are absent; the consumer decides median detection itself.

Test Plan:
- Reset then start pivot=100, size=4, samples 50,100,150,20 → lower=2/equal=1/larger=1; min_lower=20, max_lower=50, min_larger=max_larger=150; out_part seq 00,01,10,00; result_valid the cycle after the 4th accept.
- start size=0 → DONE next cycle, counts 0, extrema FF/00/FF/00; with macro, median_found=0.
- size=40 with BUFF_SIZE=32, in_valid held high → exactly 32 accepts, in_ready low afterwards, counts sum to 32.
- In RUN, toggle in_valid randomly with 8 samples all equal to pivot 7 → equal=8; lower/larger extrema untouched (FF/00); start pulses during RUN and DONE ignored.
- Hold result_ready=0 for 5 cycles in DONE → outputs stable; assert ready → IDLE; new start clears counts.
- Assert rst_n=0 after 3 of 8 samples → immediate IDLE and reset values; later start runs a clean pass. With macro, pivot=100, median_pos=2, samples 50,100,100,200 → median_found=1.

Source files
------------

// File: rtl/partition_stats.sv
// One quickselect partition pass: classifies a stream of samples against a latched pivot,
// counts/extrema per partition, re-emits tagged samples. Optional: PARTITION_MEDIAN_FOUND_EN.
module partition_stats #(
   parameter int BUFF_SIZE     = 32,
   parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [7:0]               in_pivot,
   input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
   input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
   input  logic [7:0]               in_sample,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [7:0]               out_sample,
   output logic [1:0]               out_part,
   output logic                     out_valid,
   output logic [BUFF_SIZE_BIT-1:0] lower_size,
   output logic [BUFF_SIZE_BIT-1:0] equal_size,
   output logic [BUFF_SIZE_BIT-1:0] larger_size,
   output logic [7:0]               max_lower,
   output logic [7:0]               min_lower,
   output logic [7:0]               max_larger,
   output logic [7:0]               min_larger,
   output logic [7:0]               pivot_q,
   output logic [BUFF_SIZE_BIT-1:0] median_pos_q,
   output logic                     result_valid,
   input  logic                     result_ready
`ifdef PARTITION_MEDIAN_FOUND_EN
   ,
   output logic                     median_found
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [BUFF_SIZE_BIT-1:0] BUFF_MAX = BUFF_SIZE[BUFF_SIZE_BIT-1:0];
   localparam logic [1:0] P_LOWER  = 2'b00;
   localparam logic [1:0] P_EQUAL  = 2'b01;
   localparam logic [1:0] P_LARGER = 2'b10;

   state_t                   state_q, state_d;
   logic [7:0]               pvt_q, pvt_d;
   logic [BUFF_SIZE_BIT-1:0] mpos_q, mpos_d;
   logic [BUFF_SIZE_BIT-1:0] target_q, target_d;
   logic [BUFF_SIZE_BIT-1:0] cnt_q, cnt_d;
   logic [BUFF_SIZE_BIT-1:0] lower_q, lower_d;
   logic [BUFF_SIZE_BIT-1:0] equal_q, equal_d;
   logic [BUFF_SIZE_BIT-1:0] larger_q, larger_d;
   logic [7:0]               maxl_q, maxl_d, minl_q, minl_d;
   logic [7:0]               maxg_q, maxg_d, ming_q, ming_d;
   logic [7:0]               osmp_q, osmp_d;
   logic [1:0]               opart_q, opart_d;
   logic                     ovld_q, ovld_d;
   logic                     mfound_q, mfound_d;
   logic [BUFF_SIZE_BIT:0]   le_sum;

   // Median flag uses the next-state counts so it is ready together with result_valid.
   assign le_sum = {1'b0, lower_d} + {1'b0, equal_d};

   always_comb begin
      state_d  = state_q;
      pvt_d    = pvt_q;
      mpos_d   = mpos_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      lower_d  = lower_q;
      equal_d  = equal_q;
      larger_d = larger_q;
      maxl_d   = maxl_q;
      minl_d   = minl_q;
      maxg_d   = maxg_q;
      ming_d   = ming_q;
      osmp_d   = osmp_q;
      opart_d  = opart_q;
      ovld_d   = 1'b0;
      mfound_d = mfound_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               pvt_d    = in_pivot;
               mpos_d   = in_median_pos;
               target_d = (in_buff_size > BUFF_MAX) ? BUFF_MAX : in_buff_size;
               cnt_d    = '0;
               lower_d  = '0;
               equal_d  = '0;
               larger_d = '0;
               maxl_d   = 8'h00;
               minl_d   = 8'hFF;
               maxg_d   = 8'h00;
               ming_d   = 8'hFF;
               mfound_d = 1'b0;
               state_d  = (target_d == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (in_valid) begin
               cnt_d  = cnt_q + 1'b1;
               osmp_d = in_sample;
               ovld_d = 1'b1;
               if (in_sample < pvt_q) begin
                  opart_d = P_LOWER;
                  lower_d = lower_q + 1'b1;
                  if (in_sample > maxl_q) maxl_d = in_sample;
                  if (in_sample < minl_q) minl_d = in_sample;
               end else if (in_sample == pvt_q) begin
                  opart_d = P_EQUAL;
                  equal_d = equal_q + 1'b1;
               end else begin
                  opart_d  = P_LARGER;
                  larger_d = larger_q + 1'b1;
                  if (in_sample > maxg_q) maxg_d = in_sample;
                  if (in_sample < ming_q) ming_d = in_sample;
               end
               if (cnt_d == target_q) begin
                  state_d  = DONE;
                  mfound_d = (lower_d <= mpos_q) && (le_sum > {1'b0, mpos_q});
               end
            end
         end
         DONE: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pvt_q    <= '0;
         mpos_q   <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         lower_q  <= '0;
         equal_q  <= '0;
         larger_q <= '0;
         maxl_q   <= 8'h00;
         minl_q   <= 8'hFF;
         maxg_q   <= 8'h00;
         ming_q   <= 8'hFF;
         osmp_q   <= '0;
         opart_q  <= '0;
         ovld_q   <= 1'b0;
         mfound_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pvt_q    <= pvt_d;
         mpos_q   <= mpos_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         lower_q  <= lower_d;
         equal_q  <= equal_d;
         larger_q <= larger_d;
         maxl_q   <= maxl_d;
         minl_q   <= minl_d;
         maxg_q   <= maxg_d;
         ming_q   <= ming_d;
         osmp_q   <= osmp_d;
         opart_q  <= opart_d;
         ovld_q   <= ovld_d;
         mfound_q <= mfound_d;
      end
   end

   assign in_ready     = (state_q == RUN);
   assign result_valid = (state_q == DONE);
   assign out_sample   = osmp_q;
   assign out_part     = opart_q;
   assign out_valid    = ovld_q;
   assign lower_size   = lower_q;
   assign equal_size   = equal_q;
   assign larger_size  = larger_q;
   assign max_lower    = maxl_q;
   assign min_lower    = minl_q;
   assign max_larger   = maxg_q;
   assign min_larger   = ming_q;
   assign pivot_q      = pvt_q;
   assign median_pos_q = mpos_q;
`ifdef PARTITION_MEDIAN_FOUND_EN
   assign median_found = mfound_q;
`else
   logic unused_mfound;
   assign unused_mfound = mfound_q ^ le_sum[0];
`endif

endmodule
